rs_arbiter: RTL and testbench
=============================

# rs_arbiter

Two-port round-robin arbiter and sequencer that shares one RAM_searcher connection-table engine between the host CSR path (port A) and the packet engine (port B). It sits between the requesters and the searcher. It latches the winner's request code, 4-tuple and ID, and drives them to the searcher. It then holds the request until the searcher completes, returns error and ID to the winner, and releases the searcher before the next grant. A watchdog keeps a stuck searcher from hanging the requesters.

## Interface
- TIMEOUT, 1024: maximum cycles spent in WAIT and in RELEASE before forced completion (≥2).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1 each  level request; held high until the port's done pulse is sampled, then dropped.
- a_rq, b_rq  in  2 each  request code; 2'b00 is invalid.
- a_ip_src, a_ip_dst, b_ip_src, b_ip_dst  in  32 each  IP addresses.
- a_mac_src, a_mac_dst, b_mac_src, b_mac_dst  in  24 each  MAC fields.
- a_port_src, a_port_dst, b_port_src, b_port_dst  in  16 each  TCP ports.
- a_id_in, b_id_in  in  8 each  connection ID supplied by the requester.
- a_done, b_done  out  1 each  one-cycle completion pulse.
- a_error, b_error  out  8 each  result error, valid from the done pulse until the port's next done.
- a_id_out, b_id_out  out  8 each  result ID, same validity as the error.
- rs_rq  out  2  request code to the searcher; 2'b00 means idle.
- rs_ip_src, rs_ip_dst  out  32 each  IP addresses to the searcher.
- rs_mac_src, rs_mac_dst  out  24 each  MAC fields to the searcher.
- rs_port_src, rs_port_dst  out  16 each  TCP ports to the searcher.
- rs_id_in  out  8  ID to the searcher.
- rs_done  in  1  searcher completion, level; high until the searcher sees rs_rq=00.
- rs_error  in  8  searcher error.
- rs_id_out  in  8  searcher result ID.
- busy  out  1  high in every state except IDLE.
- grant_b  out  1  owner of the current or last transaction (0=A, 1=B).

## Operation
- States: IDLE, WAIT, RELEASE, DONE.
- All outputs are registered. While rst=0, every output is 0, the FSM is in IDLE, the counter is 0 and the priority pointer is set to A.
- IDLE: if any req is high, pick the winner.
  - Both requesting: the winner is the port not served last; after reset A wins first.
  - Single requester: that port wins regardless of the pointer.
  - On grant, latch the winner's rq, tuple and ID into the rs_* registers, set grant_b, update the pointer and clear the counter.
  - If the winner's rq is 2'b00: keep rs_rq at 00, load error 8'hFE and id_out 8'h00, and go to DONE. The searcher is not touched.
  - Otherwise drive rs_rq to the winner's code and go to WAIT.
- WAIT: rs_* outputs held stable.
  - rs_done=1: capture rs_error and rs_id_out into the winner's result registers, set rs_rq to 00 and go to RELEASE.
  - Counter reaching TIMEOUT-1 first: capture error 8'hFF and id_out 8'h00, set rs_rq to 00 and go to RELEASE.
- RELEASE: rs_rq held at 00; the counter restarts at 0.
  - rs_done=0: go to DONE.
  - Counter reaching TIMEOUT-1: go to DONE anyway; the captured result is unchanged.
- DONE: the winner's done is high for exactly this cycle; next state is IDLE. The loser's outputs are untouched.
- Requests arriving while busy wait. A request that drops before its grant is lost, with no done.
- The counter saturates and never wraps.
- Any change on a_*/b_* inputs after grant has no effect until the next grant.

## Timing
- Grant decided in the IDLE cycle in which req is sampled high (cycle 0). rs_rq is valid from cycle 1.
- If the searcher raises rs_done in cycle k, rs_rq=00 from cycle k+1.
- If rs_done is low at k+1, done is high in cycle k+2 and IDLE is reached at k+3.
- Minimum request-to-done is 3 cycles (rs_done at k=1).
- Invalid code: done in cycle 1.
- Back-to-back: a request pending in cycle k+3 is granted that cycle, giving a minimum 4-cycle turnaround per searcher transaction.
- Requester contract: drop req in the cycle after done. A req still high in the IDLE cycle after done is treated as a new request.
- Asynchronous reset mid-transaction: outputs clear immediately, no done is issued and the searcher sees rs_rq=00.

## Test plan
- Single A request: rq=01, ip_src=0x0A000001, id_in=0x05; searcher asserts rs_done in cycle 3 with error 0x00 and id 0x07. Required: rs_* outputs equal A's fields from cycle 1, rs_rq=00 in cycle 4, a_done in cycle 5 with a_error=0x00 and a_id_out=0x07, b_done never asserted.
- A and B both requesting continuously from reset: grants alternate A, B, A, B, with grant_b toggling and each done going only to its owner.
- Searcher never asserts rs_done, TIMEOUT=16: rs_rq drops to 00 after 16 WAIT cycles, then done follows with error 0xFF and id_out 0x00.
- B request with rq=00: b_done in cycle 1 with b_error=0xFE; rs_rq stays 00 throughout.
- rst pulled low during WAIT: all outputs read 0 immediately. After release, a pending B request is granted and completes normally.
- A's fields change while the grant is held: rs_* outputs do not change until DONE.

Source files
------------

// File: rtl/rs_arbiter.sv
// rtl/rs_arbiter.sv - two-port round-robin arbiter/sequencer in front of one RAM_searcher
module rs_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        b_req,
  input  logic [1:0]  a_rq,
  input  logic [1:0]  b_rq,
  input  logic [31:0] a_ip_src,
  input  logic [31:0] a_ip_dst,
  input  logic [31:0] b_ip_src,
  input  logic [31:0] b_ip_dst,
  input  logic [23:0] a_mac_src,
  input  logic [23:0] a_mac_dst,
  input  logic [23:0] b_mac_src,
  input  logic [23:0] b_mac_dst,
  input  logic [15:0] a_port_src,
  input  logic [15:0] a_port_dst,
  input  logic [15:0] b_port_src,
  input  logic [15:0] b_port_dst,
  input  logic [7:0]  a_id_in,
  input  logic [7:0]  b_id_in,
  output logic        a_done,
  output logic        b_done,
  output logic [7:0]  a_error,
  output logic [7:0]  b_error,
  output logic [7:0]  a_id_out,
  output logic [7:0]  b_id_out,
  output logic [1:0]  rs_rq,
  output logic [31:0] rs_ip_src,
  output logic [31:0] rs_ip_dst,
  output logic [23:0] rs_mac_src,
  output logic [23:0] rs_mac_dst,
  output logic [15:0] rs_port_src,
  output logic [15:0] rs_port_dst,
  output logic [7:0]  rs_id_in,
  input  logic        rs_done,
  input  logic [7:0]  rs_error,
  input  logic [7:0]  rs_id_out,
  output logic        busy,
  output logic        grant_b
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE, DONE} state_t;

  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic ptr_b, ptr_b_d;
  logic [7:0] res_err, res_err_d, res_id, res_id_d;
  logic a_done_d, b_done_d, busy_d, grant_b_d;
  logic [7:0] a_error_d, b_error_d, a_id_out_d, b_id_out_d;
  logic [1:0] rs_rq_d;
  logic [31:0] rs_ip_src_d, rs_ip_dst_d;
  logic [23:0] rs_mac_src_d, rs_mac_dst_d;
  logic [15:0] rs_port_src_d, rs_port_dst_d;
  logic [7:0] rs_id_in_d;

  // ptr_b set means A was served last, so B wins a tie
  logic win_b;
  logic [1:0] win_rq;
  assign win_b  = b_req && (!a_req || ptr_b);
  assign win_rq = win_b ? b_rq : a_rq;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    ptr_b_d       = ptr_b;
    res_err_d     = res_err;
    res_id_d      = res_id;
    grant_b_d     = grant_b;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    a_error_d     = a_error;
    b_error_d     = b_error;
    a_id_out_d    = a_id_out;
    b_id_out_d    = b_id_out;
    rs_rq_d       = rs_rq;
    rs_ip_src_d   = rs_ip_src;
    rs_ip_dst_d   = rs_ip_dst;
    rs_mac_src_d  = rs_mac_src;
    rs_mac_dst_d  = rs_mac_dst;
    rs_port_src_d = rs_port_src;
    rs_port_dst_d = rs_port_dst;
    rs_id_in_d    = rs_id_in;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b_d     = win_b;
          ptr_b_d       = !win_b;
          cnt_d         = '0;
          rs_ip_src_d   = win_b ? b_ip_src   : a_ip_src;
          rs_ip_dst_d   = win_b ? b_ip_dst   : a_ip_dst;
          rs_mac_src_d  = win_b ? b_mac_src  : a_mac_src;
          rs_mac_dst_d  = win_b ? b_mac_dst  : a_mac_dst;
          rs_port_src_d = win_b ? b_port_src : a_port_src;
          rs_port_dst_d = win_b ? b_port_dst : a_port_dst;
          rs_id_in_d    = win_b ? b_id_in    : a_id_in;
          if (win_rq == 2'b00) begin
            rs_rq_d   = 2'b00;
            res_err_d = 8'hFE;
            res_id_d  = 8'h00;
            state_d   = DONE;
          end else begin
            rs_rq_d = win_rq;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rs_done) begin
          res_err_d = rs_error;
          res_id_d  = rs_id_out;
          rs_rq_d   = 2'b00;
          cnt_d     = '0;
          state_d   = RELEASE;
        end else if (cnt == CNT_LAST) begin
          res_err_d = 8'hFF;
          res_id_d  = 8'h00;
          rs_rq_d   = 2'b00;
          cnt_d     = '0;
          state_d   = RELEASE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (!rs_done || cnt == CNT_LAST) state_d = DONE;
        else cnt_d = cnt + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // DONE is only ever entered from IDLE or RELEASE, so this fires once per transaction
    if (state_d == DONE) begin
      if (grant_b_d) begin
        b_done_d   = 1'b1;
        b_error_d  = res_err_d;
        b_id_out_d = res_id_d;
      end else begin
        a_done_d   = 1'b1;
        a_error_d  = res_err_d;
        a_id_out_d = res_id_d;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  cnt <= '0;  ptr_b <= 1'b0;
      res_err <= '0;  res_id <= '0;
      grant_b <= 1'b0;  busy <= 1'b0;
      a_done <= 1'b0;  b_done <= 1'b0;
      a_error <= '0;  b_error <= '0;  a_id_out <= '0;  b_id_out <= '0;
      rs_rq <= '0;  rs_ip_src <= '0;  rs_ip_dst <= '0;
      rs_mac_src <= '0;  rs_mac_dst <= '0;
      rs_port_src <= '0;  rs_port_dst <= '0;  rs_id_in <= '0;
    end else begin
      state <= state_d;  cnt <= cnt_d;  ptr_b <= ptr_b_d;
      res_err <= res_err_d;  res_id <= res_id_d;
      grant_b <= grant_b_d;  busy <= busy_d;
      a_done <= a_done_d;  b_done <= b_done_d;
      a_error <= a_error_d;  b_error <= b_error_d;
      a_id_out <= a_id_out_d;  b_id_out <= b_id_out_d;
      rs_rq <= rs_rq_d;  rs_ip_src <= rs_ip_src_d;  rs_ip_dst <= rs_ip_dst_d;
      rs_mac_src <= rs_mac_src_d;  rs_mac_dst <= rs_mac_dst_d;
      rs_port_src <= rs_port_src_d;  rs_port_dst <= rs_port_dst_d;
      rs_id_in <= rs_id_in_d;
    end
  end

endmodule

// File: tb/tb_rs_arbiter.sv
// tb/tb_rs_arbiter.sv - scoreboard bench for rs_arbiter with a behavioural searcher
module tb_rs_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_req = 1'b0, b_req = 1'b0;
  logic [1:0] a_rq = '0, b_rq = '0;
  logic [31:0] a_ip_src = '0, a_ip_dst = '0, b_ip_src = '0, b_ip_dst = '0;
  logic [23:0] a_mac_src = '0, a_mac_dst = '0, b_mac_src = '0, b_mac_dst = '0;
  logic [15:0] a_port_src = '0, a_port_dst = '0, b_port_src = '0, b_port_dst = '0;
  logic [7:0] a_id_in = '0, b_id_in = '0;
  logic a_done, b_done, busy, grant_b;
  logic [7:0] a_error, b_error, a_id_out, b_id_out;
  logic [1:0] rs_rq;
  logic [31:0] rs_ip_src, rs_ip_dst;
  logic [23:0] rs_mac_src, rs_mac_dst;
  logic [15:0] rs_port_src, rs_port_dst;
  logic [7:0] rs_id_in;
  logic rs_done = 1'b0;
  logic [7:0] rs_error = '0, rs_id_out = '0;

  rs_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_rq(a_rq), .b_rq(b_rq),
    .a_ip_src(a_ip_src), .a_ip_dst(a_ip_dst), .b_ip_src(b_ip_src), .b_ip_dst(b_ip_dst),
    .a_mac_src(a_mac_src), .a_mac_dst(a_mac_dst), .b_mac_src(b_mac_src), .b_mac_dst(b_mac_dst),
    .a_port_src(a_port_src), .a_port_dst(a_port_dst), .b_port_src(b_port_src), .b_port_dst(b_port_dst),
    .a_id_in(a_id_in), .b_id_in(b_id_in),
    .a_done(a_done), .b_done(b_done), .a_error(a_error), .b_error(b_error),
    .a_id_out(a_id_out), .b_id_out(b_id_out),
    .rs_rq(rs_rq), .rs_ip_src(rs_ip_src), .rs_ip_dst(rs_ip_dst),
    .rs_mac_src(rs_mac_src), .rs_mac_dst(rs_mac_dst),
    .rs_port_src(rs_port_src), .rs_port_dst(rs_port_dst), .rs_id_in(rs_id_in),
    .rs_done(rs_done), .rs_error(rs_error), .rs_id_out(rs_id_out),
    .busy(busy), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ndone = 0;

  typedef struct { bit port; logic [7:0] err; logic [7:0] id; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // searcher model: mode 0 answers after sr_dly busy cycles, 1 never answers, 2 holds rs_done stuck high
  int sr_mode = 0, sr_dly = 1, sr_cnt = 0;
  logic [7:0] sr_err = '0, sr_xor = '0;
  always @(negedge clk) begin
    if (!rst || rs_rq == 2'b00) begin
      sr_cnt = 0;
      rs_done = (sr_mode == 2);
    end else begin
      sr_cnt++;
      rs_done = (sr_mode == 2) || (sr_mode == 0 && sr_cnt >= sr_dly);
    end
    rs_error = sr_err;
    rs_id_out = rs_id_in ^ sr_xor;
  end

  always @(negedge clk) begin
    if (rst && (a_done || b_done)) begin
      exp_t e;
      ndone++;
      chk("done_exclusive", {a_done, b_done}, a_done ? 2'b10 : 2'b01);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_owner", b_done, e.port);
        chk("grant_b", grant_b, e.port);
        chk("result_error", b_done ? b_error : a_error, e.err);
        chk("result_id", b_done ? b_id_out : a_id_out, e.id);
      end
    end
  end

  task automatic push(input bit port, input logic [7:0] err, input logic [7:0] id);
    exp_t e;
    e.port = port; e.err = err; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {a_done, b_done, a_error, b_error, a_id_out, b_id_out, rs_rq, rs_id_in, busy, grant_b}, 64'h0);
    chk({tag, "_ip"}, {rs_ip_src, rs_ip_dst}, 64'h0);
    chk({tag, "_mac"}, {rs_mac_src, rs_mac_dst, rs_port_src}, 64'h0);
    chk({tag, "_pdst"}, rs_port_dst, 64'h0);
  endtask

  // req already raised in an IDLE cycle; counts cycles from grant to the port's done pulse
  task automatic txn(input bit port, input int exp_cyc);
    int n = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n++;
      if (port ? b_done : a_done) break;
      if (n > 100) break;
    end
    chk(port ? "b_done_cycle" : "a_done_cycle", n, exp_cyc);
    if (port) b_req = 1'b0; else a_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // both ports requesting continuously from reset: A, B, A, B
    sr_mode = 0; sr_dly = 1; sr_err = 8'h33; sr_xor = 8'h0F;
    a_rq = 2'b01; a_id_in = 8'h10; b_rq = 2'b10; b_id_in = 8'h20;
    push(0, 8'h33, 8'h1F); push(1, 8'h33, 8'h2F);
    push(0, 8'h33, 8'h1F); push(1, 8'h33, 8'h2F);
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rr_done_count", ndone, 4);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // single A request, searcher answers in cycle 3
    sr_dly = 3; sr_err = 8'h00; sr_xor = 8'h02;
    a_rq = 2'b01; a_ip_src = 32'h0A000001; a_ip_dst = 32'h0A000002;
    a_mac_src = 24'hABCDEF; a_port_dst = 16'h1F90; a_id_in = 8'h05;
    push(0, 8'h00, 8'h07);
    a_req = 1'b1;
    fork
      txn(0, 5);
      begin
        @(posedge clk); @(negedge clk);
        chk("c1_rs_rq", rs_rq, 2'b01);
        chk("c1_rs_ip", {rs_ip_src, rs_ip_dst}, {32'h0A000001, 32'h0A000002});
        chk("c1_rs_misc", {rs_mac_src, rs_port_dst, rs_id_in}, {24'hABCDEF, 16'h1F90, 8'h05});
        chk("c1_busy", busy, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("c3_rs_rq", rs_rq, 2'b01);
        @(negedge clk);
        chk("c4_rs_rq", rs_rq, 2'b00);
      end
    join

    // invalid code on B: done in cycle 1, searcher untouched
    b_rq = 2'b00; b_id_in = 8'h99;
    push(1, 8'hFE, 8'h00);
    b_req = 1'b1;
    fork
      txn(1, 1);
      begin
        @(posedge clk); @(negedge clk);
        chk("inv_rs_rq", rs_rq, 2'b00);
        chk("inv_busy", busy, 1'b1);
      end
    join

    // searcher never answers: WAIT timeout after 16 cycles
    sr_mode = 1;
    a_rq = 2'b11; a_id_in = 8'h44;
    push(0, 8'hFF, 8'h00);
    a_req = 1'b1;
    fork
      txn(0, 18);
      begin
        @(posedge clk);
        repeat (16) @(negedge clk);
        chk("to_c16_rs_rq", rs_rq, 2'b11);
        @(negedge clk);
        chk("to_c17_rs_rq", rs_rq, 2'b00);
      end
    join

    // rs_done stuck high: RELEASE times out, captured result kept
    sr_mode = 2; sr_err = 8'h77; sr_xor = 8'h0F;
    b_rq = 2'b01; b_id_in = 8'h55;
    push(1, 8'h77, 8'h5A);
    b_req = 1'b1;
    txn(1, 18);
    sr_mode = 0;
    @(negedge clk);

    // A's fields change while the grant is held
    sr_dly = 3; sr_err = 8'h12; sr_xor = 8'h01;
    a_rq = 2'b01; a_ip_src = 32'hC0A80001; a_id_in = 8'h66;
    push(0, 8'h12, 8'h67);
    a_req = 1'b1;
    fork
      txn(0, 5);
      begin
        @(posedge clk); @(negedge clk);
        a_rq = 2'b10; a_ip_src = 32'h01020304; a_id_in = 8'hEE;
        for (int c = 2; c <= 3; c++) begin
          @(negedge clk);
          chk("hold_rs", {rs_rq, rs_ip_src, rs_id_in}, {2'b01, 32'hC0A80001, 8'h66});
        end
      end
    join

    // reset asserted mid-WAIT with B pending
    sr_mode = 1;
    a_rq = 2'b01; a_id_in = 8'h31;
    a_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    b_rq = 2'b10; b_id_in = 8'h21; b_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    a_req = 1'b0;
    @(negedge clk);
    sr_mode = 0; sr_dly = 2; sr_err = 8'h09; sr_xor = 8'h00;
    push(1, 8'h09, 8'h21);
    rst = 1'b1;
    txn(1, 4);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
